conv_output_gather: RTL and testbench

// Collects the full-width result row of one convolution unit and packs the valid

---
 rtl/conv_output_gather.sv | 130 +++++++++++++
 tb/tb_conv_output_gather.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/conv_output_gather.sv
// Gathers the valid output segments of one conv-unit result row into a packed row.
// Each parallel mode has a table of inclusive {lo,hi} ranges that are copied one per cycle.
module conv_output_gather #(
    parameter int CONV_SIZE = 31,
    parameter int CONV_BITS = 10,
    parameter int PAR_MAX   = 6,
    parameter int OUT_MAX   = 28,
    // 4-bit segment count per mode, mode 0 in the low nibble
    parameter logic [11:0] PAR_NUM = {4'd6, 4'd2, 4'd1},
    // 8-bit fields indexed by ((mode*PAR_MAX + seg)*2 + {0:lo,1:hi})
    parameter logic [3*PAR_MAX*16-1:0] PAR_OUT = {
        8'd30, 8'd30, 8'd24, 8'd24, 8'd18, 8'd18, 8'd12, 8'd12, 8'd6,  8'd6,  8'd0, 8'd0,
        8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd23, 8'd14, 8'd9, 8'd0,
        8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd27, 8'd0
    }
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     in_mode,
    input  logic [CONV_SIZE*CONV_BITS-1:0] in_row,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_MAX*CONV_BITS-1:0]   out_row,
    output logic [$clog2(OUT_MAX+1)-1:0]   out_len,
    output logic                           err
);

    localparam int LW = $clog2(OUT_MAX + 1);
    localparam int PW = $clog2(CONV_SIZE);
    localparam int SW = $clog2(PAR_MAX);

    typedef enum logic [1:0] {IDLE, GATHER, OUTPUT} state_t;

    state_t                                state_q;
    logic [1:0]                            mode_q;
    logic [CONV_SIZE-1:0][CONV_BITS-1:0]   row_q;
    logic [OUT_MAX-1:0][CONV_BITS-1:0]     pack_q, pack_d;
    logic [SW-1:0]                         seg_q;
    logic [LW-1:0]                         wptr_q, len_d;
    logic                                  rdy_q, vld_q, err_q;

    logic [7:0]    lo8, hi8, len8, wp8, k8;
    logic [3:0]    num;
    logic [PW-1:0] idx;
    logic          last_seg;
    int            base;

    // Current segment's range and the pack register with that range written in
    always_comb begin
        base     = (int'(mode_q) * PAR_MAX + int'(seg_q)) * 16;
        lo8      = PAR_OUT[base +: 8];
        hi8      = PAR_OUT[base + 8 +: 8];
        len8     = hi8 - lo8 + 8'd1;
        len_d    = LW'(len8);
        wp8      = 8'(wptr_q);
        num      = PAR_NUM[int'(mode_q) * 4 +: 4];
        last_seg = (4'(seg_q) == num - 4'd1);
        pack_d   = pack_q;
        k8       = 8'd0;
        idx      = '0;
        for (int k = 0; k < OUT_MAX; k++) begin
            k8 = 8'(k);
            if (k8 >= wp8 && k8 < wp8 + len8) begin
                idx       = PW'(lo8 + k8 - wp8);
                pack_d[k] = row_q[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            mode_q  <= '0;
            row_q   <= '0;
            pack_q  <= '0;
            seg_q   <= '0;
            wptr_q  <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (in_valid && rdy_q) begin
                        if (in_mode == 2'd3) begin
                            err_q <= 1'b1;
                        end else begin
                            row_q   <= in_row;
                            mode_q  <= in_mode;
                            pack_q  <= '0;
                            seg_q   <= '0;
                            wptr_q  <= '0;
                            rdy_q   <= 1'b0;
                            state_q <= GATHER;
                        end
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                GATHER: begin
                    pack_q <= pack_d;
                    wptr_q <= wptr_q + len_d;
                    seg_q  <= seg_q + 1'b1;
                    if (last_seg) state_q <= OUTPUT;
                end
                OUTPUT: begin
                    // First OUTPUT cycle only arms out_valid; handshake is taken once it is visible
                    if (!vld_q) begin
                        vld_q <= 1'b1;
                    end else if (out_ready) begin
                        vld_q   <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = vld_q;
    assign out_row   = pack_q;
    assign out_len   = wptr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conv_output_gather.sv
// Directed bench for conv_output_gather: modes 0/1/2, backpressure, illegal mode, mid-row reset.
module tb_conv_output_gather;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_mode = 2'd0;
    logic [309:0] in_row = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [279:0] out_row;
    logic [4:0]   out_len;
    logic         err;

    int checks = 0;
    int fails  = 0;

    conv_output_gather dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_len(out_len),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [309:0] ramp(input bit desc);
        logic [309:0] r;
        r = '0;
        for (int i = 0; i < 31; i++) r[i*10 +: 10] = desc ? 10'(1000 - i) : 10'(i);
        return r;
    endfunction

    // Hand-derived packed rows
    function automatic logic [279:0] exp_m0();
        logic [279:0] r;
        r = '0;
        for (int k = 0; k < 28; k++) r[k*10 +: 10] = 10'(k);
        return r;
    endfunction

    function automatic logic [279:0] exp_m1();
        logic [279:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r[k*10 +: 10] = 10'(k);
        for (int k = 10; k < 20; k++) r[k*10 +: 10] = 10'(k + 4);
        return r;
    endfunction

    function automatic logic [279:0] exp_m2();
        logic [279:0] r;
        r = '0;
        r[0*10 +: 10] = 10'd1000;
        r[1*10 +: 10] = 10'd994;
        r[2*10 +: 10] = 10'd988;
        r[3*10 +: 10] = 10'd982;
        r[4*10 +: 10] = 10'd976;
        r[5*10 +: 10] = 10'd970;
        return r;
    endfunction

    // Offer a row until accepted; returns 1ns after the accept edge with inputs scrambled
    task automatic send(input logic [1:0] m, input logic [309:0] r);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_row   = r;
        while (n < 50) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        chk("accept_timeout", {319'd0, n < 50}, 320'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = 2'd2;
        in_row   = '1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("vld_drop", {319'd0, out_valid}, 320'd0);
    endtask

    task automatic run_row(input string tag, input logic [1:0] m, input logic [309:0] r,
                           input int exp_lat, input int exp_len, input logic [279:0] exp_row);
        int lat;
        send(m, r);
        wait_out(lat);
        chk({tag, "_lat"}, 320'(lat), 320'(exp_lat));
        chk({tag, "_len"}, {315'd0, out_len}, 320'(exp_len));
        chk({tag, "_row"}, {40'd0, out_row}, {40'd0, exp_row});
        chk({tag, "_rdy"}, {319'd0, in_ready}, 320'd0);
        take();
    endtask

    initial begin
        int lat;
        #12;
        chk("rst_rdy", {319'd0, in_ready}, 320'd0);
        chk("rst_vld", {319'd0, out_valid}, 320'd0);
        chk("rst_len", {315'd0, out_len}, 320'd0);
        chk("rst_row", {40'd0, out_row}, 320'd0);
        chk("rst_err", {319'd0, err}, 320'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", {319'd0, in_ready}, 320'd1);

        run_row("m0", 2'd0, ramp(1'b0), 2, 28, exp_m0());
        run_row("m1", 2'd1, ramp(1'b0), 3, 20, exp_m1());
        run_row("m2", 2'd2, ramp(1'b1), 7, 6, exp_m2());

        // Backpressure with a second row already offered
        send(2'd0, ramp(1'b0));
        wait_out(lat);
        chk("bp_lat", 320'(lat), 320'd2);
        in_valid = 1'b1;
        in_mode  = 2'd1;
        in_row   = ramp(1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp_vld", {319'd0, out_valid}, 320'd1);
            chk("bp_len", {315'd0, out_len}, 320'd28);
            chk("bp_row", {40'd0, out_row}, {40'd0, exp_m0()});
            chk("bp_rdy", {319'd0, in_ready}, 320'd0);
        end
        take();
        chk("bp_rdy_after", {319'd0, in_ready}, 320'd1);
        run_row("bp_next", 2'd1, ramp(1'b0), 3, 20, exp_m1());

        // Illegal mode
        send(2'd3, ramp(1'b0));
        chk("err_pulse", {319'd0, err}, 320'd1);
        @(posedge clk);
        #1;
        chk("err_clear", {319'd0, err}, 320'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("err_novld", {319'd0, out_valid}, 320'd0);
        end
        run_row("after_err", 2'd0, ramp(1'b0), 2, 28, exp_m0());

        // Reset in the middle of a mode 2 gather
        send(2'd2, ramp(1'b1));
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_vld", {319'd0, out_valid}, 320'd0);
        chk("mid_rst_rdy", {319'd0, in_ready}, 320'd0);
        chk("mid_rst_len", {315'd0, out_len}, 320'd0);
        chk("mid_rst_row", {40'd0, out_row}, 320'd0);
        chk("mid_rst_err", {319'd0, err}, 320'd0);
        @(negedge clk);
        rstn = 1'b1;
        run_row("post_rst", 2'd1, ramp(1'b0), 3, 20, exp_m1());

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
